instruction_decode_sequencer: RTL and testbench
===============================================

INSTRUCTION_DECODE_SEQUENCER -- requirements
Module: instruction_decode_sequencer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, operand/immediate width; REGADDR_WIDTH, 5, register address width; RESLT_SELCT_WIDTH, 3, result-select width.
REQ-002 SHALL have ports, one per line, in this order:
- clk  input  1  the single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr_in  input  32  RV32I instruction word.
- instr_valid  input  1  instr_in is valid.
- instr_ready  output  1  the sequencer accepts an instruction.
- rf_readAddr  output  REGADDR_WIDTH  register-file read address.
- rf_readData  input  DATA_WIDTH  register-file read data; valid the cycle after the address is driven.
- frame_ready  input  1  the downstream frame may be loaded.
- illegal_instr  output  1  one-cycle pulse on a rejected opcode.
- Eleven frame data outputs: aOperand, aLoc, bOperand, bLoc, immediateVal, immediateSelect, unsignedSelect, subtractEnable, resultSelect, writeSelect, writeEnable. Widths are DATA_WIDTH, REGADDR_WIDTH, DATA_WIDTH, REGADDR_WIDTH, DATA_WIDTH, 1, 1, 1, RESLT_SELCT_WIDTH, REGADDR_WIDTH, 1.
- frame_we  output  1  common write enable for all eleven frame fields.

Function
REQ-003 SHALL implement states IDLE, RD_A, RD_B, CAP, ISSUE, with one-hot or binary encoding.
REQ-004 instr_ready SHALL be 1 only in IDLE; the sequencer accepts when instr_valid&&instr_ready and registers instr_in.
REQ-005 Accepted opcode 0110011 (R-type) SHALL sequence IDLE->RD_A->RD_B->CAP->ISSUE.
REQ-006 Accepted opcode 0010011 (I-type) SHALL sequence IDLE->RD_A->CAP->ISSUE.
REQ-007 Accepted opcode 0110111 (LUI) SHALL sequence IDLE->ISSUE.
REQ-008 Every other opcode, and R/I funct3 001 or 101 (shifts), SHALL pulse illegal_instr for the cycle after acceptance, return to IDLE, and assert no frame_we.
REQ-009 rf_readAddr SHALL be rs1 in RD_A, rs2 in RD_B, and 0 otherwise.
REQ-010 aOperand SHALL latch rf_readData at the end of RD_B (R-type) or at the end of CAP (I-type); bOperand SHALL latch rf_readData at the end of CAP (R-type).
REQ-011 For I-type and LUI, bOperand and bLoc SHALL be 0.
REQ-012 For LUI, aOperand and aLoc SHALL be 0.
REQ-013 immediateVal SHALL be sign-extended instr[31:20] for I-type, {instr[31:12],12'b0} for LUI, and 0 for R-type.
REQ-014 immediateSelect SHALL be 1 for I-type and LUI.
REQ-015 aLoc SHALL be rs1 and bLoc SHALL be rs2 (R-type).
REQ-016 writeSelect SHALL be rd, and writeEnable SHALL be (rd!=0).
REQ-017 resultSelect SHALL be 0 for ADD/SUB/ADDI/LUI, 1 for SLT/SLTU/SLTI/SLTIU, 2 for AND, 3 for OR, and 4 for XOR (including the immediate forms).
REQ-018 subtractEnable SHALL be 1 for R-type funct3=000 with funct7=0100000, and for all SLT* forms.
REQ-019 unsignedSelect SHALL be 1 for SLTU and SLTIU only.
REQ-020 In ISSUE, frame_we SHALL equal frame_ready; when frame_ready=1 the FSM moves to IDLE next cycle; when frame_ready=0 the FSM holds ISSUE with all outputs stable.
REQ-021 Minimum R-type latency SHALL be 4 cycles from the acceptance edge to the frame_we cycle; back-to-back instruction spacing is 5 cycles.
REQ-022 instr_valid arriving while not in IDLE SHALL be ignored (no acceptance).

Reset
REQ-023 While reset=0, the FSM SHALL go asynchronously to IDLE and every output, including the frame fields, frame_we and illegal_instr, SHALL be 0.
REQ-024 instr_ready SHALL be 1 from the first edge after reset deasserts.
REQ-025 Reset asserted mid-sequence SHALL discard the instruction without any frame_we.

Configuration
REQ-026 Macro X0_SHORTCUT_EN SHALL control skipping of register-file reads for source register x0.
REQ-027 With X0_SHORTCUT_EN defined, a source register of 0 SHALL skip its read and use operand value 0:
- I-type with rs1=0: IDLE->ISSUE.
- R-type with rs1=0 and rs2=0: IDLE->ISSUE.
- R-type with rs1=0 only: RD_B->CAP->ISSUE.
- R-type with rs2=0 only: RD_A->CAP->ISSUE, with A latched at the end of CAP.
REQ-028 Without X0_SHORTCUT_EN, x0 SHALL be read like any other register, and sequences SHALL follow REQ-005 and REQ-006.

Verification
REQ-029 ADD x3,x1,x2 with rf x1=5, x2=7, frame_ready=1 -> frame_we on cycle 4: aOperand=5, bOperand=7, aLoc=1, bLoc=2, writeSelect=3, writeEnable=1, resultSelect=0, subtractEnable=0.
REQ-030 ADDI x4,x1,-1 with x1=5 -> frame_we on cycle 3: immediateVal=0xFFFFFFFF, immediateSelect=1, bOperand=0.
REQ-031 SLTU x5,x1,x2 with frame_ready held 0 for 3 cycles -> ISSUE held with outputs stable; frame_we=1 in the cycle frame_ready rises; unsignedSelect=1, subtractEnable=1, resultSelect=1.
REQ-032 Opcode 0000011 -> illegal_instr pulses for one cycle, frame_we stays 0, instr_ready=1 two cycles after acceptance.
REQ-033 reset=0 during RD_B of an R-type -> all outputs 0 immediately, no frame_we, next instruction accepted normally.
REQ-034 With X0_SHORTCUT_EN defined, ADDI x1,x0,9 -> frame_we on cycle 1, aOperand=0, immediateVal=9, rf_readAddr never nonzero.

Source files
------------

// File: rtl/instruction_decode_sequencer.sv
// RV32I ALU-op decode sequencer: reads rs1/rs2 from the register file and issues one decoded frame.
// Build option X0_SHORTCUT_EN: skip register-file reads for source register x0 (operand taken as 0).
module instruction_decode_sequencer #(
   parameter int DATA_WIDTH        = 32,
   parameter int REGADDR_WIDTH     = 5,
   parameter int RESLT_SELCT_WIDTH = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [31:0]                  instr_in,
   input  logic                         instr_valid,
   output logic                         instr_ready,
   output logic [REGADDR_WIDTH-1:0]     rf_readAddr,
   input  logic [DATA_WIDTH-1:0]        rf_readData,
   input  logic                         frame_ready,
   output logic                         illegal_instr,
   output logic [DATA_WIDTH-1:0]        aOperand,
   output logic [REGADDR_WIDTH-1:0]     aLoc,
   output logic [DATA_WIDTH-1:0]        bOperand,
   output logic [REGADDR_WIDTH-1:0]     bLoc,
   output logic [DATA_WIDTH-1:0]        immediateVal,
   output logic                         immediateSelect,
   output logic                         unsignedSelect,
   output logic                         subtractEnable,
   output logic [RESLT_SELCT_WIDTH-1:0] resultSelect,
   output logic [REGADDR_WIDTH-1:0]     writeSelect,
   output logic                         writeEnable,
   output logic                         frame_we
);
   // state | meaning
   // IDLE  | ready for an instruction (instr_ready high unless an illegal pulse is out)
   // RD_A  | rf_readAddr = rs1
   // RD_B  | rf_readAddr = rs2
   // CAP   | last read data arriving, captured at the end of the cycle
   // ISSUE | frame complete, frame_we follows frame_ready
   typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, ISSUE} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B} src_t;

   state_t state_q;
   src_t   rd_src_q;
   logic   ready_q, illegal_q, need_b_q;
   logic [REGADDR_WIDTH-1:0] addr_q, rs2_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [REGADDR_WIDTH-1:0] rd, rs1, rs2;
   logic dec_r, dec_i, dec_lui, alu_ok, dec_legal, dec_sub, dec_uns, dec_need_b;
   logic [RESLT_SELCT_WIDTH-1:0] dec_res;
   logic [DATA_WIDTH-1:0] dec_imm;
   state_t dec_first;
   logic [REGADDR_WIDTH-1:0] dec_first_addr;

   assign opcode = instr_in[6:0];
   assign funct3 = instr_in[14:12];
   assign rd     = REGADDR_WIDTH'(instr_in[11:7]);
   assign rs1    = REGADDR_WIDTH'(instr_in[19:15]);
   assign rs2    = REGADDR_WIDTH'(instr_in[24:20]);

   always_comb begin
      dec_r      = (opcode == 7'b0110011);
      dec_i      = (opcode == 7'b0010011);
      dec_lui    = (opcode == 7'b0110111);
      alu_ok     = 1'b1;
      dec_sub    = 1'b0;
      dec_uns    = 1'b0;
      dec_res    = '0;
      dec_imm    = '0;
      dec_first  = IDLE;
      dec_need_b = 1'b0;
      case (funct3)
         3'b000:  dec_sub = dec_r && (instr_in[31:25] == 7'b0100000);
         3'b010:  begin dec_res = RESLT_SELCT_WIDTH'(1); dec_sub = 1'b1; end
         3'b011:  begin dec_res = RESLT_SELCT_WIDTH'(1); dec_sub = 1'b1; dec_uns = 1'b1; end
         3'b100:  dec_res = RESLT_SELCT_WIDTH'(4);
         3'b110:  dec_res = RESLT_SELCT_WIDTH'(3);
         3'b111:  dec_res = RESLT_SELCT_WIDTH'(2);
         default: alu_ok = 1'b0;
      endcase
      dec_legal = dec_lui || ((dec_r || dec_i) && alu_ok);
      if (dec_i) begin
         dec_imm = {{(DATA_WIDTH-12){instr_in[31]}}, instr_in[31:20]};
      end else if (dec_lui) begin
         dec_res = '0;
         dec_sub = 1'b0;
         dec_uns = 1'b0;
         dec_imm = DATA_WIDTH'({instr_in[31:12], 12'b0});
      end
`ifdef X0_SHORTCUT_EN
      if (dec_lui || (dec_i && rs1 == '0) || (dec_r && rs1 == '0 && rs2 == '0))
         dec_first = ISSUE;
      else if (dec_r && rs1 == '0)
         dec_first = RD_B;
      else
         dec_first = RD_A;
      dec_need_b = dec_r && (rs2 != '0);
`else
      dec_first  = dec_lui ? ISSUE : RD_A;
      dec_need_b = dec_r;
`endif
      dec_first_addr = (dec_first == RD_A) ? rs1 : (dec_first == RD_B) ? rs2 : '0;
   end

   assign instr_ready   = ready_q;
   assign illegal_instr = illegal_q;
   assign rf_readAddr   = addr_q;
   assign frame_we      = (state_q == ISSUE) && frame_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         rd_src_q        <= SRC_NONE;
         ready_q         <= 1'b0;
         illegal_q       <= 1'b0;
         need_b_q        <= 1'b0;
         addr_q          <= '0;
         rs2_q           <= '0;
         aOperand        <= '0;
         aLoc            <= '0;
         bOperand        <= '0;
         bLoc            <= '0;
         immediateVal    <= '0;
         immediateSelect <= 1'b0;
         unsignedSelect  <= 1'b0;
         subtractEnable  <= 1'b0;
         resultSelect    <= '0;
         writeSelect     <= '0;
         writeEnable     <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         addr_q    <= '0;
         // Read data always belongs to the address driven one cycle earlier.
         rd_src_q  <= (state_q == RD_A) ? SRC_A : (state_q == RD_B) ? SRC_B : SRC_NONE;
         if (rd_src_q == SRC_A) aOperand <= rf_readData;
         if (rd_src_q == SRC_B) bOperand <= rf_readData;
         case (state_q)
            IDLE: begin
               if (ready_q && instr_valid) begin
                  ready_q <= 1'b0;
                  if (!dec_legal) begin
                     illegal_q <= 1'b1;
                  end else begin
                     state_q         <= dec_first;
                     addr_q          <= dec_first_addr;
                     need_b_q        <= dec_need_b;
                     rs2_q           <= rs2;
                     aOperand        <= '0;
                     bOperand        <= '0;
                     aLoc            <= dec_lui ? '0 : rs1;
                     bLoc            <= dec_r ? rs2 : '0;
                     immediateVal    <= dec_imm;
                     immediateSelect <= !dec_r;
                     unsignedSelect  <= dec_uns;
                     subtractEnable  <= dec_sub;
                     resultSelect    <= dec_res;
                     writeSelect     <= rd;
                     writeEnable     <= (rd != '0);
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            RD_A: begin
               state_q <= need_b_q ? RD_B : CAP;
               addr_q  <= need_b_q ? rs2_q : '0;
            end
            RD_B:  state_q <= CAP;
            CAP:   state_q <= ISSUE;
            ISSUE: begin
               if (frame_ready) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instruction_decode_sequencer.sv
// Directed self-checking bench for instruction_decode_sequencer with a one-cycle-latency register file model.
module tb_instruction_decode_sequencer;
   logic clk = 1'b0;
   logic reset;
   logic [31:0] instr_in;
   logic instr_valid, instr_ready;
   logic [4:0] rf_readAddr;
   logic [31:0] rf_readData;
   logic frame_ready, illegal_instr;
   logic [31:0] aOperand, bOperand, immediateVal;
   logic [4:0] aLoc, bLoc, writeSelect;
   logic immediateSelect, unsignedSelect, subtractEnable, writeEnable, frame_we;
   logic [2:0] resultSelect;

   int tests = 0;
   int fails = 0;
   logic [31:0] rf_mem [0:31];
   logic [4:0] addr_or;
   logic mon = 1'b0;
   logic [125:0] all_out;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;

   instruction_decode_sequencer dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .rf_readAddr(rf_readAddr), .rf_readData(rf_readData),
      .frame_ready(frame_ready), .illegal_instr(illegal_instr),
      .aOperand(aOperand), .aLoc(aLoc), .bOperand(bOperand), .bLoc(bLoc),
      .immediateVal(immediateVal), .immediateSelect(immediateSelect),
      .unsignedSelect(unsignedSelect), .subtractEnable(subtractEnable),
      .resultSelect(resultSelect), .writeSelect(writeSelect), .writeEnable(writeEnable),
      .frame_we(frame_we)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rf_readData <= rf_mem[rf_readAddr];
   always @(negedge clk) if (mon) addr_or = addr_or | rf_readAddr;

   assign all_out = {instr_ready, rf_readAddr, illegal_instr, aOperand, aLoc, bOperand, bLoc,
                     immediateVal, immediateSelect, unsignedSelect, subtractEnable, resultSelect,
                     writeSelect, writeEnable, frame_we};

   typedef struct {
      logic [31:0] w;
      int          lat;
      logic [31:0] a, b, imm;
      logic [4:0]  al, bl, ws;
      logic        isel, uns, sub, we;
      logic [2:0]  res;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] w, output int lat);
      @(negedge clk);
      instr_in = w;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      lat = 1;
      while (frame_we !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
      rf_mem[1] = 32'd5;
      rf_mem[2] = 32'd7;
      reset = 1'b0; instr_in = '0; instr_valid = 1'b0; frame_ready = 1'b1; addr_or = '0;

      vecs[0] = '{{12'hFFF, 5'd1, 3'b000, 5'd4, OP_I}, 3, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
      vecs[1] = '{{7'b0100000, 5'd1, 5'd2, 3'b000, 5'd8, OP_R}, 4, 32'd7, 32'd5, 32'd0, 5'd2, 5'd1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
      vecs[2] = '{{7'b0, 5'd2, 5'd1, 3'b111, 5'd0, OP_R}, 4, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
      vecs[3] = '{{12'h7FF, 5'd2, 3'b100, 5'd9, OP_I}, 3, 32'd7, 32'd0, 32'h7FF, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
      vecs[4] = '{{12'hFFE, 5'd1, 3'b011, 5'd10, OP_I}, 3, 32'd5, 32'd0, 32'hFFFF_FFFE, 5'd1, 5'd0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1};
      vecs[5] = '{{12'h010, 5'd1, 3'b110, 5'd11, OP_I}, 3, 32'd5, 32'd0, 32'h10, 5'd1, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
      vecs[6] = '{{20'h12345, 5'd7, OP_LUI}, 1, 32'd0, 32'd0, 32'h1234_5000, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
      vecs[7] = '{{7'b0, 5'd1, 5'd2, 3'b010, 5'd12, OP_R}, 4, 32'd7, 32'd5, 32'd0, 5'd2, 5'd1, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};

      // Reset state and release
      repeat (2) @(negedge clk);
      check("reset_all_outputs_zero", 128'(all_out), 128'd0);
      reset = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 128'(instr_ready), 128'd1);

      // ADD x3,x1,x2 with cycle-by-cycle checks; a second valid during the sequence is ignored
      instr_in = {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, OP_R};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("add_c1_ready", 128'(instr_ready), 128'd0);
      check("add_c1_addr_rs1", 128'(rf_readAddr), 128'd1);
      instr_in = {20'hABCDE, 5'd9, OP_LUI};
      @(negedge clk);
      check("add_c2_addr_rs2", 128'(rf_readAddr), 128'd2);
      check("add_c2_no_we", 128'(frame_we), 128'd0);
      @(negedge clk);
      check("add_c3_addr_zero", 128'(rf_readAddr), 128'd0);
      check("add_c3_no_we", 128'(frame_we), 128'd0);
      instr_valid = 1'b0;
      @(negedge clk);
      check("add_c4_we", 128'(frame_we), 128'd1);
      check("add_a", 128'(aOperand), 128'd5);
      check("add_b", 128'(bOperand), 128'd7);
      check("add_aloc", 128'(aLoc), 128'd1);
      check("add_bloc", 128'(bLoc), 128'd2);
      check("add_ws", 128'(writeSelect), 128'd3);
      check("add_we", 128'(writeEnable), 128'd1);
      check("add_res", 128'(resultSelect), 128'd0);
      check("add_sub", 128'(subtractEnable), 128'd0);
      check("add_isel", 128'(immediateSelect), 128'd0);
      @(negedge clk);
      check("add_after_we_low", 128'(frame_we), 128'd0);
      check("add_after_ready", 128'(instr_ready), 128'd1);

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].w, lat);
         check($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
         check($sformatf("v%0d_a", i), 128'(aOperand), 128'(vecs[i].a));
         check($sformatf("v%0d_b", i), 128'(bOperand), 128'(vecs[i].b));
         check($sformatf("v%0d_imm", i), 128'(immediateVal), 128'(vecs[i].imm));
         check($sformatf("v%0d_locs", i), 128'({aLoc, bLoc, writeSelect}), 128'({vecs[i].al, vecs[i].bl, vecs[i].ws}));
         check($sformatf("v%0d_flags", i), 128'({immediateSelect, unsignedSelect, subtractEnable, writeEnable}),
               128'({vecs[i].isel, vecs[i].uns, vecs[i].sub, vecs[i].we}));
         check($sformatf("v%0d_res", i), 128'(resultSelect), 128'(vecs[i].res));
      end

      // SLTU x5,x1,x2 with frame_ready low for 3 cycles in ISSUE
      @(negedge clk);
      frame_ready = 1'b0;
      instr_in = {7'b0, 5'd2, 5'd1, 3'b011, 5'd5, OP_R};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("sltu_hold%0d_we", k), 128'(frame_we), 128'd0);
         check($sformatf("sltu_hold%0d_ops", k), 128'({aOperand, bOperand, writeSelect}), 128'({32'd5, 32'd7, 5'd5}));
         check($sformatf("sltu_hold%0d_ready", k), 128'(instr_ready), 128'd0);
         if (k < 2) @(negedge clk);
      end
      @(negedge clk);
      frame_ready = 1'b1;
      #1;
      check("sltu_we_on_ready", 128'(frame_we), 128'd1);
      check("sltu_flags", 128'({unsignedSelect, subtractEnable, resultSelect}), 128'({1'b1, 1'b1, 3'd1}));
      @(negedge clk);
      check("sltu_ready_back", 128'(instr_ready), 128'd1);

      // Illegal opcode (load) and an illegal shift
      instr_in = {12'd0, 5'd1, 3'b010, 5'd6, 7'b0000011};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      check("ld_c1_illegal", 128'({illegal_instr, instr_ready, frame_we}), 128'({1'b1, 1'b0, 1'b0}));
      @(negedge clk);
      check("ld_c2_back", 128'({illegal_instr, instr_ready, frame_we}), 128'({1'b0, 1'b1, 1'b0}));
      instr_in = {7'b0, 5'd3, 5'd1, 3'b001, 5'd1, OP_I};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      check("slli_c1_illegal", 128'({illegal_instr, instr_ready, frame_we}), 128'({1'b1, 1'b0, 1'b0}));
      @(negedge clk);
      check("slli_c2_back", 128'({illegal_instr, instr_ready, frame_we}), 128'({1'b0, 1'b1, 1'b0}));

      // Reset during RD_B discards the instruction
      instr_in = {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, OP_R};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midreset_all_zero", 128'(all_out), 128'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_ready", 128'(instr_ready), 128'd1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("midreset_no_we%0d", k), 128'(frame_we), 128'd0);
         @(negedge clk);
      end
      send({20'h00042, 5'd13, OP_LUI}, lat);
      check("post_reset_lui_lat", 128'(lat), 128'd1);
      check("post_reset_lui_imm", 128'(immediateVal), 128'h42000);

      // ADDI x1,x0,9: x0 shortcut when enabled
      addr_or = '0;
      mon = 1'b1;
      send({12'd9, 5'd0, 3'b000, 5'd1, OP_I}, lat);
      mon = 1'b0;
`ifdef X0_SHORTCUT_EN
      check("x0_addi_lat", 128'(lat), 128'd1);
`else
      check("x0_addi_lat", 128'(lat), 128'd3);
`endif
      check("x0_addi_a", 128'(aOperand), 128'd0);
      check("x0_addi_imm", 128'(immediateVal), 128'd9);
      check("x0_addr_never_nonzero", 128'(addr_or), 128'd0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
